// File: rtl/tpg_pkg.sv
// Shared types and constants for the test pattern generator.
package tpg_pkg;

    localparam int unsigned TPG_LATENCY = 2;

    typedef enum logic [2:0] {
        MODE_BLACK    = 3'd0,
        MODE_BORDER   = 3'd1,
        MODE_BARS     = 3'd2,
        MODE_CHECKER  = 3'd3,
        MODE_GRADIENT = 3'd4,
        MODE_BOX      = 3'd5,
        MODE_WHITE6   = 3'd6,
        MODE_WHITE7   = 3'd7
    } tpg_mode_e;

    // Palette as {R,G,B} channel-enable bits; expanded to any channel width.
    localparam logic [2:0] RGB3_WHITE   = 3'b111;
    localparam logic [2:0] RGB3_YELLOW  = 3'b110;
    localparam logic [2:0] RGB3_CYAN    = 3'b011;
    localparam logic [2:0] RGB3_GREEN   = 3'b010;
    localparam logic [2:0] RGB3_MAGENTA = 3'b101;
    localparam logic [2:0] RGB3_RED     = 3'b100;
    localparam logic [2:0] RGB3_BLUE    = 3'b001;
    localparam logic [2:0] RGB3_BLACK   = 3'b000;

    function automatic logic [2:0] bar_rgb3(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB3_WHITE;
            3'd1:    return RGB3_YELLOW;
            3'd2:    return RGB3_CYAN;
            3'd3:    return RGB3_GREEN;
            3'd4:    return RGB3_MAGENTA;
            3'd5:    return RGB3_RED;
            3'd6:    return RGB3_BLUE;
            default: return RGB3_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/tpg_box_mover.sv
// Bouncing-box position state; steps once per frame start while enabled.
module tpg_box_mover #(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned BOX_STEP = 2
) (
    input  logic               clk_pixel,
    input  logic               rst_n,
    input  logic               i_fs,
    input  logic               i_en,
    input  logic [COORD_W-1:0] i_sw,
    input  logic [COORD_W-1:0] i_sh,
    output logic [COORD_W-1:0] o_bx,
    output logic [COORD_W-1:0] o_by
);

    localparam logic [COORD_W-1:0] C_SPAN = COORD_W'(BOX_SIZE + BOX_STEP);
    localparam logic [COORD_W-1:0] C_STEP = COORD_W'(BOX_STEP);

    logic [COORD_W-1:0] r_bx;
    logic [COORD_W-1:0] r_by;
    logic               r_dx;
    logic               r_dy;

    // A direction flip costs one frame with the position held.
    function automatic logic [COORD_W:0] f_step(input logic dir,
                                                input logic [COORD_W-1:0] pos,
                                                input logic [COORD_W-1:0] size);
        if (!dir) begin
            if (pos + C_SPAN > size) return {1'b1, pos};
            return {1'b0, pos + C_STEP};
        end
        if (pos < C_STEP) return {1'b0, pos};
        return {1'b1, pos - C_STEP};
    endfunction

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_bx <= '0;
            r_by <= '0;
            r_dx <= 1'b0;
            r_dy <= 1'b0;
        end else if (i_fs && i_en) begin
            {r_dx, r_bx} <= f_step(r_dx, r_bx, i_sw);
            {r_dy, r_by} <= f_step(r_dy, r_by, i_sh);
        end
    end

    assign o_bx = r_bx;
    assign o_by = r_by;

endmodule

// File: rtl/test_pattern_gen.sv
// Two-stage runtime-selectable RGB test pattern generator.
// Define TPG_MOVING_BOX_EN to build the bouncing-box mode (5); otherwise mode 5 is solid white.
module test_pattern_gen
    import tpg_pkg::*;
#(
    parameter int unsigned COLOR_W      = 8,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned CHECKER_LOG2 = 5,
    parameter int unsigned BOX_SIZE     = 32,
    parameter int unsigned BOX_STEP     = 2
) (
    input  logic                 clk_pixel,
    input  logic                 rst_n,
    input  logic [2:0]           mode_i,
    input  logic [COORD_W-1:0]   cx,
    input  logic [COORD_W-1:0]   cy,
    input  logic [COORD_W-1:0]   screen_start_x,
    input  logic [COORD_W-1:0]   screen_start_y,
    input  logic [COORD_W-1:0]   frame_width,
    input  logic [COORD_W-1:0]   frame_height,
    output logic [3*COLOR_W-1:0] rgb,
    output logic [2:0]           mode_o,
    output logic [15:0]          frame_count
);

    localparam int unsigned RGB_W = 3 * COLOR_W;

    logic               w_fs;
    logic [2:0]         w_mode;
    logic               w_active;
    logic [COORD_W-1:0] w_ax;
    logic [COORD_W-1:0] w_ay;
    logic [COORD_W-1:0] w_sw;
    logic [COORD_W-1:0] w_sh;
    logic [COORD_W-1:0] w_bar_cnt;
    logic [2:0]         w_bar_idx;
    logic [RGB_W-1:0]   w_rgb;

    logic               r_active;
    logic               r_left;
    logic               r_top;
    logic               r_right;
    logic               r_bottom;
    logic               r_chk;
    logic [COLOR_W-1:0] r_grad;
    tpg_mode_e          r_mode_s1;
    logic [COORD_W-1:0] r_bw;
    logic [COORD_W-1:0] r_bar_cnt;
    logic [2:0]         r_bar_idx;

    assign w_fs     = (cx == '0) && (cy == '0);
    // The frame-start pixel already uses the newly requested mode.
    assign w_mode   = w_fs ? mode_i : mode_o;
    assign w_active = (cx >= screen_start_x) && (cy >= screen_start_y);
    assign w_ax     = cx - screen_start_x;
    assign w_ay     = cy - screen_start_y;
    assign w_sw     = frame_width - screen_start_x;
    assign w_sh     = frame_height - screen_start_y;

    // Bar column counter restarts at every line's first active pixel.
    always_comb begin
        w_bar_cnt = r_bar_cnt + COORD_W'(1);
        w_bar_idx = r_bar_idx;
        if (w_ax == '0) begin
            w_bar_cnt = '0;
            w_bar_idx = '0;
        end else if (r_bar_cnt == r_bw - COORD_W'(1)) begin
            w_bar_cnt = '0;
            if (r_bar_idx != 3'd7) w_bar_idx = r_bar_idx + 3'd1;
        end
    end

`ifdef TPG_MOVING_BOX_EN
    logic [COORD_W-1:0] w_bx;
    logic [COORD_W-1:0] w_by;
    logic               w_in_box;
    logic [COORD_W-1:0] r_ax;
    logic [COORD_W-1:0] r_ay;

    tpg_box_mover #(
        .COORD_W  (COORD_W),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box_mover (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .i_fs      (w_fs),
        .i_en      (tpg_mode_e'(mode_o) == MODE_BOX),
        .i_sw      (w_sw),
        .i_sh      (w_sh),
        .o_bx      (w_bx),
        .o_by      (w_by)
    );

    // Compared in stage 2 so the whole frame sees the post-update position.
    assign w_in_box = (r_ax >= w_bx) && (r_ax < w_bx + COORD_W'(BOX_SIZE)) &&
                      (r_ay >= w_by) && (r_ay < w_by + COORD_W'(BOX_SIZE));

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_ax <= '0;
            r_ay <= '0;
        end else begin
            r_ax <= w_ax;
            r_ay <= w_ay;
        end
    end
`endif

    always_comb begin
        w_rgb = '0;
        if (r_active) begin
            case (r_mode_s1)
                MODE_BLACK:    w_rgb = '0;
                MODE_BORDER:   w_rgb = {{COLOR_W{r_left}}, {COLOR_W{r_top}},
                                        {COLOR_W{r_right || r_bottom}}};
                MODE_BARS:     w_rgb = {{COLOR_W{bar_rgb3(r_bar_idx)[2]}},
                                        {COLOR_W{bar_rgb3(r_bar_idx)[1]}},
                                        {COLOR_W{bar_rgb3(r_bar_idx)[0]}}};
                MODE_CHECKER:  w_rgb = {RGB_W{r_chk}};
                MODE_GRADIENT: w_rgb = {3{r_grad}};
`ifdef TPG_MOVING_BOX_EN
                MODE_BOX:      w_rgb = {RGB_W{w_in_box}};
`endif
                default:       w_rgb = '1;
            endcase
        end
    end

    // Stage 1 (coordinates, flags, mode, frame state) and stage 2 (rgb).
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_active    <= 1'b0;
            r_left      <= 1'b0;
            r_top       <= 1'b0;
            r_right     <= 1'b0;
            r_bottom    <= 1'b0;
            r_chk       <= 1'b0;
            r_grad      <= '0;
            r_mode_s1   <= MODE_BLACK;
            r_bw        <= '0;
            r_bar_cnt   <= '0;
            r_bar_idx   <= '0;
            mode_o      <= '0;
            frame_count <= '0;
            rgb         <= '0;
        end else begin
            r_active  <= w_active;
            r_left    <= (w_ax == '0);
            r_top     <= (w_ay == '0);
            r_right   <= (w_ax == w_sw - COORD_W'(1));
            r_bottom  <= (w_ay == w_sh - COORD_W'(1));
            r_chk     <= w_ax[CHECKER_LOG2] ^ w_ay[CHECKER_LOG2];
            r_grad    <= COLOR_W'(w_ax);
            r_mode_s1 <= tpg_mode_e'(w_mode);
            r_bar_cnt <= w_bar_cnt;
            r_bar_idx <= w_bar_idx;
            if (w_fs) begin
                mode_o      <= mode_i;
                frame_count <= frame_count + 16'd1;
                r_bw        <= w_sw >> 3;
            end
            rgb <= w_rgb;
        end
    end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen: vector table, hand sequences and random stimulus vs a pixel model.
module tb_test_pattern_gen;

    localparam int SSX = 160;
    localparam int SSY = 45;
    localparam int FW  = 800;
    localparam int FH  = 525;
    localparam int SW  = FW - SSX;
    localparam int SH  = FH - SSY;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [2:0]  mode_i;
    logic [9:0]  cx, cy;
    logic [9:0]  screen_start_x, screen_start_y, frame_width, frame_height;
    logic [23:0] rgb;
    logic [2:0]  mode_o;
    logic [15:0] frame_count;

    test_pattern_gen dut (
        .clk_pixel      (clk_pixel),
        .rst_n          (rst_n),
        .mode_i         (mode_i),
        .cx             (cx),
        .cy             (cy),
        .screen_start_x (screen_start_x),
        .screen_start_y (screen_start_y),
        .frame_width    (frame_width),
        .frame_height   (frame_height),
        .rgb            (rgb),
        .mode_o         (mode_o),
        .frame_count    (frame_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state, updated per frame start.
    int          m_mode, m_fc, m_bw, m_bx, m_by;
    bit          m_dx, m_dy;
    logic [23:0] prev_exp;
    bit          prev_valid;

    typedef struct {
        logic [2:0]  mode;
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_mode = 0; m_fc = 0; m_bw = 0;
        m_bx = 0; m_by = 0; m_dx = 0; m_dy = 0;
        prev_valid = 0;
    endtask

    function automatic logic [23:0] bar_color(input int idx);
        logic [23:0] pal [8];
        pal = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return pal[idx];
    endfunction

    // Expected pixel from the visible rules, in plain integer arithmetic.
    function automatic logic [23:0] model_rgb(input int md, input int x, input int y);
        int ax, ay, idx, g;
        if (x < SSX || y < SSY) return 24'h0;
        ax = x - SSX;
        ay = y - SSY;
        case (md)
            0: return 24'h0;
            1: return {(ax == 0) ? 8'hFF : 8'h00, (ay == 0) ? 8'hFF : 8'h00,
                       (ax == SW - 1 || ay == SH - 1) ? 8'hFF : 8'h00};
            2: begin
                idx = (m_bw == 0) ? 0 : ax / m_bw;
                if (idx > 7) idx = 7;
                return bar_color(idx);
            end
            3: return ((((ax / 32) % 2) ^ ((ay / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h0;
            4: begin
                g = ax % 256;
                return {8'(g), 8'(g), 8'(g)};
            end
`ifdef TPG_MOVING_BOX_EN
            5: return (ax >= m_bx && ax < m_bx + 32 && ay >= m_by && ay < m_by + 32)
                      ? 24'hFFFFFF : 24'h0;
`endif
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic void box_axis(inout int pos, inout bit dir, input int size);
        if (!dir) begin
            if (pos + 34 > size) dir = 1;
            else pos = pos + 2;
        end else begin
            if (pos < 2) dir = 0;
            else pos = pos - 2;
        end
    endfunction

    // Present one pixel, advance a clock, check the pixel presented one step earlier.
    task automatic step(input int x, input int y);
        logic [23:0] e;
        cx = 10'(x);
        cy = 10'(y);
        if (x == 0 && y == 0) begin
`ifdef TPG_MOVING_BOX_EN
            if (m_mode == 5) begin
                box_axis(m_bx, m_dx, SW);
                box_axis(m_by, m_dy, SH);
            end
`endif
            m_mode = int'(mode_i);
            m_fc   = (m_fc + 1) % 65536;
            m_bw   = SW / 8;
        end
        e = model_rgb(m_mode, x, y);
        @(posedge clk_pixel);
        #1;
        if (prev_valid) check("rgb", 32'(rgb), 32'(prev_exp));
        check("mode_o", 32'(mode_o), 32'(m_mode));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        prev_exp   = e;
        prev_valid = 1;
    endtask

    task automatic box_frame();
        int px, py;
        step(0, 0);
        px = SSX + m_bx;
        py = SSY + m_by;
        step(px, py);
        step(px + 31, py);
        step(px + 32, py);
        step(px, py + 31);
        step(px, py + 32);
        if (m_bx > 0) step(px - 1, py);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rmodes [7];
        rmodes = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

        vecs[0]  = '{3'd1, 160, 100, 24'hFF0000};
        vecs[1]  = '{3'd1, 300,  45, 24'h00FF00};
        vecs[2]  = '{3'd1, 160,  45, 24'hFFFF00};
        vecs[3]  = '{3'd1, 799, 300, 24'h0000FF};
        vecs[4]  = '{3'd1, 100,  20, 24'h000000};
        vecs[5]  = '{3'd1, 799, 524, 24'h0000FF};
        vecs[6]  = '{3'd3, 160,  45, 24'h000000};
        vecs[7]  = '{3'd3, 192,  45, 24'hFFFFFF};
        vecs[8]  = '{3'd3, 192,  77, 24'h000000};
        vecs[9]  = '{3'd4, 160,  50, 24'h000000};
        vecs[10] = '{3'd4, 415,  50, 24'hFFFFFF};
        vecs[11] = '{3'd4, 416,  50, 24'h000000};
        vecs[12] = '{3'd6, 500, 300, 24'hFFFFFF};
        vecs[13] = '{3'd7, 500, 300, 24'hFFFFFF};
        vecs[14] = '{3'd0, 500, 300, 24'h000000};
        vecs[15] = '{3'd6, 159, 300, 24'h000000};

        screen_start_x = 10'(SSX);
        screen_start_y = 10'(SSY);
        frame_width    = 10'(FW);
        frame_height   = 10'(FH);
        mode_i = 3'd1;
        cx = 10'd5;
        cy = 10'd5;
        rst_n = 1'b0;
        #12;
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_mode_o", 32'(mode_o), 32'h0);
        check("reset_frame_count", 32'(frame_count), 32'h0);
        @(negedge clk_pixel);
        rst_n = 1'b1;
        reset_model();

        // Active pixels before the first frame start stay black.
        for (int x = 150; x < 200; x++) step(x, 100);

        foreach (vecs[i]) begin
            mode_i = vecs[i].mode;
            step(0, 0);
            step(vecs[i].x, vecs[i].y);
            step(0, 1);
            check($sformatf("vec%0d", i), 32'(rgb), 32'(vecs[i].exp));
        end

        // Mode request changes mid-frame; latch waits for the next frame start.
        mode_i = 3'd1;
        step(0, 0);
        step(300, 100);
        mode_i = 3'd2;
        step(400, 200);
        step(500, 200);
        check("mode_hold", 32'(mode_o), 32'd1);
        step(0, 0);
        check("mode_switch", 32'(mode_o), 32'd2);
        for (int x = 150; x < FW; x++) step(x, 100);
        step(0, 1);

        mode_i = 3'd5;
        for (int f = 0; f < 400; f++) box_frame();
        step(0, 0);
        step(300, 200);

        // Asynchronous reset in the middle of a frame.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rgb", 32'(rgb), 32'h0);
        check("midrst_frame_count", 32'(frame_count), 32'h0);
        check("midrst_mode_o", 32'(mode_o), 32'h0);
        repeat (2) @(negedge clk_pixel);
        rst_n = 1'b1;
        reset_model();
        for (int x = 300; x < 330; x++) step(x, 200);
        for (int f = 0; f < 5; f++) box_frame();

        for (int n = 0; n < 3000; n++) begin
            mode_i = rmodes[$urandom_range(0, 6)];
            if ($urandom_range(0, 39) == 0) step(0, 0);
            else step(int'($urandom_range(0, FW - 1)), int'($urandom_range(0, FH - 1)));
        end
        step(0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
